// File: rtl/img_pkg.sv
// Shared constants and state encoding for the image UART transmit path.
package img_pkg;

  localparam int IMG_W        = 128;
  localparam int IMG_H        = 128;
  localparam int NUM_PIXELS   = IMG_W * IMG_H;
  localparam int ADDR_W       = 14;
  localparam int CLKS_PER_BIT = 10417;  // 100 MHz / 9600 baud
  localparam int RD_LATENCY   = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    STOP,
    DONE
  } tx_state_t;

endpackage

// File: rtl/image_uart_tx_byte.sv
// Serialises one byte as 8N1, LSB first; TxD is registered so it lags the phase by one cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = img_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       bit_end,
  output logic       last_data,
  output logic       done,
  output logic       TxD
);
  import img_pkg::*;

  localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        phase;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign busy      = (phase != IDLE);
  assign bit_end   = busy && (baud_cnt == CNT_MAX);
  assign last_data = bit_end && (phase == DATA) && (bit_idx == 3'd7);
  assign done      = bit_end && (phase == STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      TxD      <= 1'b1;
    end else begin
      // every phase change happens on bit_end, so this also clears on entry
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (phase)
        IDLE: begin
          TxD      <= 1'b1;
          baud_cnt <= '0;
          if (load) begin
            shift   <= data;
            bit_idx <= '0;
            phase   <= START;
          end
        end
        START: begin
          TxD <= 1'b0;
          if (bit_end) phase <= DATA;
        end
        DATA: begin
          TxD <= shift[0];
          if (bit_end) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) phase <= STOP;
          end
        end
        STOP: begin
          TxD <= 1'b1;
          if (bit_end) phase <= IDLE;
        end
        default: begin
          TxD   <= 1'b1;
          phase <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/image_uart_tx.sv
// Reads NUM_PIXELS bytes from BRAM in address order and sends each over the UART line.
module image_uart_tx #(
  parameter int CLKS_PER_BIT = img_pkg::CLKS_PER_BIT,
  parameter int NUM_PIXELS   = img_pkg::NUM_PIXELS,
  parameter int ADDR_W       = img_pkg::ADDR_W,
  parameter int RD_LATENCY   = img_pkg::RD_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ena_tx,
  output logic              wea_tx,
  output logic [ADDR_W-1:0] addr_tx,
  output logic [7:0]        din_tx,
  input  logic [7:0]        dout_tx,
  output logic              TxD,
  output logic              busy,
  output logic              ImTxComplete
);
  import img_pkg::*;

  // one extra bit so NUM_PIXELS == 2**ADDR_W never wraps the counter
  localparam int            PW       = ADDR_W + 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIXELS - 1);
  localparam logic [1:0]    LAT_LAST = 2'(RD_LATENCY - 1);

  tx_state_t     state;
  logic [PW-1:0] pix_cnt;
  logic [1:0]    lat_cnt;
  logic          byte_busy, bit_end, last_data, byte_done, load;

  assign wea_tx  = 1'b0;
  assign din_tx  = 8'h00;
  assign addr_tx = pix_cnt[ADDR_W-1:0];
  assign load    = (state == WAIT) && (lat_cnt == LAT_LAST) && !byte_busy;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (dout_tx),
    .busy      (byte_busy),
    .bit_end   (bit_end),
    .last_data (last_data),
    .done      (byte_done),
    .TxD       (TxD)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      lat_cnt      <= '0;
      ena_tx       <= 1'b0;
      busy         <= 1'b0;
      ImTxComplete <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= FETCH;
          pix_cnt <= '0;
          ena_tx  <= 1'b1;
          busy    <= 1'b1;
        end
        FETCH: begin
          ena_tx  <= 1'b0;
          lat_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (load) state <= START;
          else if (lat_cnt != LAT_LAST) lat_cnt <= lat_cnt + 2'd1;
        end
        START: if (bit_end) state <= DATA;
        DATA:  if (last_data) state <= STOP;
        STOP: if (byte_done) begin
          if (pix_cnt == LAST_PIX) begin
            state        <= DONE;
            busy         <= 1'b0;
            ImTxComplete <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
            ena_tx  <= 1'b1;
            state   <= FETCH;
          end
        end
        DONE: if (!start) begin
          state        <= IDLE;
          ImTxComplete <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
